gp_reg_bank: RTL
================

GP_REG_BANK -- requirements
Module: gp_reg_bank

Interface
REQ-001 Parameter N_REG, default 32, number of 32-bit general registers, range 1..1000.
REQ-002 Parameter PAGE_ID, default 1, value of addr[31:10] that selects this bank.
REQ-003 Parameter PULSE_MASK, default 0 (N_REG bits), bit i set marks register i as a pulse register.
REQ-004 Parameter SHADOW_MASK, default 0 (N_REG bits), bit i set marks register i as a shadowed, commit-updated register.
REQ-005 Parameter PULSE_LEN, default 1, pulse width in clk cycles, range 1..255.
REQ-006 clk  input  1  clock; all logic is on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 addr  input  32  bus address: [31:10] is the page, [9:0] is the register offset.
REQ-009 data  input  32  write data.
REQ-010 be  input  4  byte enables; be[k] qualifies data[8k+7:8k].
REQ-011 wren  input  1  write strobe, one access per cycle.
REQ-012 rden  input  1  read strobe, one access per cycle.
REQ-013 sts_in  input  32  status set bits, sampled every cycle.
REQ-014 rd_data  output  32  read return data.
REQ-015 rd_valid  output  1  rd_data qualifier, one-cycle pulse.
REQ-016 reg_out  output  N_REG*32  register values; register i occupies bits [32i+31:32i].
REQ-017 pulse_out  output  N_REG  per-register pulse; bits not set in PULSE_MASK are held at 0.
REQ-018 err  output  1  one-cycle pulse for any in-page access at an unmapped offset.

Function
REQ-019 The offset map SHALL be: 0..N_REG-1 general registers; N_REG COMMIT; N_REG+1 STATUS (W1C); N_REG+2 ERRCNT (read-only); all other offsets unmapped.
REQ-020 Stage 1 SHALL register the page hit (addr[31:10]==PAGE_ID), offset, data, be, wren and rden; stage 2 SHALL perform the access.
REQ-021 A write accepted in cycle k SHALL be visible on reg_out at cycle k+2 for non-shadowed registers.
REQ-022 A read accepted in cycle k SHALL assert rd_valid with rd_data at cycle k+2; an unmapped read SHALL return 0.
REQ-023 A write SHALL update only the bytes with be set; be==0 SHALL leave the register unchanged but still count as an access.
REQ-024 When wren and rden are both asserted to the same offset in one cycle, the read SHALL return the pre-write value.
REQ-025 A shadowed register write SHALL update the staging copy only; a COMMIT write with data[0]=1 and be[0]=1 SHALL copy every staging copy to reg_out in that same stage-2 cycle.
REQ-026 A staging write followed by a COMMIT in the next cycle SHALL commit the new staging value.
REQ-027 A pulse-register write with nonzero masked data SHALL drive pulse_out[i] high for exactly PULSE_LEN cycles starting at k+2; a rewrite during the pulse SHALL restart the count.
REQ-028 STATUS SHALL be sticky: each cycle, bits set in sts_in SHALL be ORed in; a write SHALL clear the bits where data=1 under be; on a simultaneous set and clear of the same bit, set SHALL win.
REQ-029 ERRCNT SHALL be a 16-bit counter, incremented once per unmapped access and saturating at 0xFFFF; a write to ERRCNT with data=0 SHALL clear it.
REQ-030 Accesses with no page hit SHALL produce no effect, no rd_valid and no err.

Reset
REQ-031 While rst is high, all registers, staging copies, STATUS, ERRCNT, pulse counters, pipeline valids, reg_out, pulse_out, rd_valid, rd_data and err SHALL be 0.
REQ-032 A reset asserted mid-pulse SHALL terminate the pulse in the following cycle, and accesses in flight SHALL be discarded.

Structure
REQ-033 Shared package gp_reg_pkg SHALL hold the page IDs (GLOBAL=0, CAPTURE=1, LASER=2, BUS=3, OTHER=4), the COMMIT/STATUS/ERRCNT offset functions of N_REG, and the clog2 helper.
REQ-034 Sub-module gp_pulse_stretch (counter-based, width PULSE_LEN) SHALL be instantiated once per PULSE_MASK bit by a generate loop.

Verification
REQ-035 Write reg 3 = 0xA5A5_1234 with be=4'b0101 over a prior value of 0 -> reg_out[3] = 0x00A5_0034 at k+2; read at k+3 -> rd_data = 0x00A5_0034 at k+5.
REQ-036 With SHADOW_MASK[2]=1, write reg 2 = 7 -> reg_out[2] stays 0; COMMIT with data=1 the next cycle -> reg_out[2] = 7.
REQ-037 With PULSE_LEN=4 and PULSE_MASK[5]=1, write reg 5 = 1 at k and again at k+2 -> pulse_out[5] high from k+2 through k+7.
REQ-038 With sts_in bit 0 held high and a STATUS write of 1 -> bit 0 remains 1; with bit 0 released, a STATUS write of 1 -> bit 0 = 0.
REQ-039 Access offset N_REG+5 three times -> err pulses 3 times and ERRCNT reads 3; an access to page PAGE_ID+1 -> no response at all.
REQ-040 Assert rst at k+1 after a pulse write at k -> pulse_out stays 0 and reg_out = 0.

Source files
------------

// File: rtl/gp_reg_pkg.sv
// Shared definitions for the general-purpose register banks: page IDs,
// control-register offsets and small helpers.
package gp_reg_pkg;

    typedef enum logic [21:0] {
        PAGE_GLOBAL  = 22'd0,
        PAGE_CAPTURE = 22'd1,
        PAGE_LASER   = 22'd2,
        PAGE_BUS     = 22'd3,
        PAGE_OTHER   = 22'd4
    } page_id_e;

    // Control registers sit directly above the general registers.
    function automatic logic [9:0] commit_off(input int n_reg);
        return 10'(n_reg);
    endfunction

    function automatic logic [9:0] status_off(input int n_reg);
        return 10'(n_reg + 1);
    endfunction

    function automatic logic [9:0] errcnt_off(input int n_reg);
        return 10'(n_reg + 2);
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++)
            m[8*k +: 8] = {8{be[k]}};
        return m;
    endfunction

endpackage

// File: rtl/gp_pulse_stretch.sv
// Stretches a single-cycle trigger into a PULSE_LEN-cycle pulse; a new
// trigger while the pulse is running reloads the count.
module gp_pulse_stretch
    import gp_reg_pkg::*;
#(
    parameter int PULSE_LEN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_i,
    output logic pulse_o
);
    localparam int CW = clog2(PULSE_LEN + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (trig_i)
            cnt_d = CW'(PULSE_LEN);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/gp_reg_bank.sv
// Paged register bank: general/pulse/shadowed registers plus COMMIT,
// sticky STATUS and an unmapped-access counter. Two-stage access pipeline.
module gp_reg_bank
    import gp_reg_pkg::*;
#(
    parameter int               N_REG       = 32,
    parameter int unsigned      PAGE_ID     = 1,
    parameter logic [N_REG-1:0] PULSE_MASK  = '0,
    parameter logic [N_REG-1:0] SHADOW_MASK = '0,
    parameter int               PULSE_LEN   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic [31:0]          data,
    input  logic [3:0]           be,
    input  logic                 wren,
    input  logic                 rden,
    input  logic [31:0]          sts_in,
    output logic [31:0]          rd_data,
    output logic                 rd_valid,
    output logic [N_REG*32-1:0]  reg_out,
    output logic [N_REG-1:0]     pulse_out,
    output logic                 err
);
    localparam logic [9:0] OFF_COMMIT = commit_off(N_REG);
    localparam logic [9:0] OFF_STATUS = status_off(N_REG);
    localparam logic [9:0] OFF_ERRCNT = errcnt_off(N_REG);

    // Stage 1: registered request
    logic        s1_hit_q, s1_wr_q, s1_rd_q;
    logic [9:0]  s1_off_q;
    logic [31:0] s1_data_q;
    logic [3:0]  s1_be_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit_q  <= 1'b0;
            s1_wr_q   <= 1'b0;
            s1_rd_q   <= 1'b0;
            s1_off_q  <= '0;
            s1_data_q <= '0;
            s1_be_q   <= '0;
        end else begin
            s1_hit_q  <= (addr[31:10] == 22'(PAGE_ID));
            s1_wr_q   <= wren;
            s1_rd_q   <= rden;
            s1_off_q  <= addr[9:0];
            s1_data_q <= data;
            s1_be_q   <= be;
        end
    end

    // Stage 2: access
    logic        s2_wr, s2_rd, s2_unmapped, s2_commit;
    logic [31:0] s2_mask, s2_wdata;

    assign s2_wr       = s1_hit_q & s1_wr_q;
    assign s2_rd       = s1_hit_q & s1_rd_q;
    assign s2_mask     = byte_mask(s1_be_q);
    assign s2_wdata    = s1_data_q & s2_mask;
    assign s2_unmapped = (s2_wr | s2_rd) && (s1_off_q > OFF_ERRCNT);
    assign s2_commit   = s2_wr && (s1_off_q == OFF_COMMIT) && s1_data_q[0] && s1_be_q[0];

    logic [N_REG-1:0][31:0] reg_q, reg_d, stg_q, stg_d;
    logic [31:0]            sts_q, sts_d, rd_data_q, rd_data_d;
    logic [15:0]            errcnt_q, errcnt_d;
    logic                   rd_valid_q, err_q;

    always_comb begin
        reg_d = reg_q;
        stg_d = stg_q;
        for (int i = 0; i < N_REG; i++) begin
            if (s2_wr && (s1_off_q == 10'(i))) begin
                if (SHADOW_MASK[i]) stg_d[i] = (stg_q[i] & ~s2_mask) | s2_wdata;
                else                reg_d[i] = (reg_q[i] & ~s2_mask) | s2_wdata;
            end
            if (SHADOW_MASK[i] && s2_commit)
                reg_d[i] = stg_q[i];
        end

        // Set wins over clear on the same bit.
        sts_d = sts_q | sts_in;
        if (s2_wr && (s1_off_q == OFF_STATUS))
            sts_d = (sts_q & ~s2_wdata) | sts_in;

        errcnt_d = errcnt_q;
        if (s2_unmapped) begin
            if (errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
        end else if (s2_wr && (s1_off_q == OFF_ERRCNT) && (s1_data_q == '0)) begin
            errcnt_d = '0;
        end

        // Reads see the pre-write state; shadowed registers return the live value.
        rd_data_d = '0;
        if (s2_rd) begin
            for (int i = 0; i < N_REG; i++)
                if (s1_off_q == 10'(i)) rd_data_d = reg_q[i];
            if (s1_off_q == OFF_STATUS) rd_data_d = sts_q;
            if (s1_off_q == OFF_ERRCNT) rd_data_d = {16'h0, errcnt_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q      <= '0;
            stg_q      <= '0;
            sts_q      <= '0;
            errcnt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            reg_q      <= reg_d;
            stg_q      <= stg_d;
            sts_q      <= sts_d;
            errcnt_q   <= errcnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= s2_rd;
            err_q      <= s2_unmapped;
        end
    end

    assign reg_out  = reg_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

    for (genvar g = 0; g < N_REG; g++) begin : g_pulse
        if (PULSE_MASK[g]) begin : g_on
            logic trig;
            assign trig = s2_wr && (s1_off_q == 10'(g)) && (s2_wdata != '0);
            gp_pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_stretch (
                .clk     (clk),
                .rst     (rst),
                .trig_i  (trig),
                .pulse_o (pulse_out[g])
            );
        end else begin : g_off
            assign pulse_out[g] = 1'b0;
        end
    end

endmodule
